aec_line_feeder: RTL and testbench

//  Upstream stage of AEC. Collects an expression byte-by-byte from a host stream
//  (valid/ready), buffers it up to and including '=', then replays it into AEC:
//  one char per cycle, with a one-cycle start strobe on the first char. It

---
 rtl/aec_line_feeder_if.sv | 28 ++
 rtl/aec_line_feeder.sv | 156 +++++++++++++++
 tb/tb_aec_line_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aec_line_feeder_if.sv
// Host and AEC handshake bundle for the line feeder.
interface aec_line_feeder_if;
    // host byte stream in
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    // replay into AEC and its result back
    logic       aec_ready;
    logic [7:0] aec_ascii;
    logic       aec_valid;
    logic [6:0] aec_result;
    // result back to host
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_result;
    logic       out_err;
    logic       line_drop;

    modport slave (
        input  in_valid, in_data, aec_valid, aec_result, out_ready,
        output in_ready, aec_ready, aec_ascii, out_valid, out_result, out_err, line_drop
    );

    modport master (
        output in_valid, in_data, aec_valid, aec_result, out_ready,
        input  in_ready, aec_ready, aec_ascii, out_valid, out_result, out_err, line_drop
    );
endinterface

// File: rtl/aec_line_feeder.sv
// Buffers one '='-terminated expression from the host, replays it into AEC
// one char per cycle, then returns the AEC result (or a timeout) to the host.
module aec_line_feeder #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    aec_line_feeder_if.slave bus
);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_FILL, S_SEND, S_WAIT, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  rd_q, rd_d;
    logic           ovf_q, ovf_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           in_ready_q, in_ready_d;
    logic           aec_ready_q, aec_ready_d;
    logic [7:0]     aec_ascii_q, aec_ascii_d;
    logic           out_valid_q, out_valid_d;
    logic [6:0]     out_result_q, out_result_d;
    logic           out_err_q, out_err_d;
    logic           line_drop_q, line_drop_d;

    logic [7:0]     mem_q [DEPTH];
    logic           wr_en;
    logic           accept, is_ws, is_eq, full;

    assign accept = bus.in_valid && in_ready_q;
    assign is_ws  = (bus.in_data == 8'h20) || (bus.in_data == 8'h0D) || (bus.in_data == 8'h0A);
    assign is_eq  = (bus.in_data == 8'h3D);
    // last slot is kept free so a terminating '=' always fits
    assign full   = (len_q == LW'(DEPTH)) || (!is_eq && (len_q == LW'(DEPTH - 1)));

    // next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_d         = rd_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        aec_ready_d  = 1'b0;
        aec_ascii_d  = 8'h00;
        line_drop_d  = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept && !is_ws) begin
                    if (is_eq && ovf_q) begin
                        line_drop_d = 1'b1;
                        len_d       = '0;
                        ovf_d       = 1'b0;
                    end else if (is_eq && (len_q == '0)) begin
                        // empty line, nothing to evaluate
                    end else if (ovf_q) begin
                        // swallow the rest of an over-long line
                    end else if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        len_d = len_q + 1'b1;
                        if (is_eq) begin
                            rd_d    = '0;
                            state_d = S_SEND;
                        end
                    end
                end
            end
            S_SEND: begin
                aec_ascii_d = mem_q[rd_q[AW-1:0]];
                aec_ready_d = (rd_q == '0);
                rd_d        = rd_q + 1'b1;
                if (rd_q == len_q - 1'b1) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
            end
            S_WAIT: begin
                if (bus.aec_valid) begin
                    out_result_d = bus.aec_result;
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    out_result_d = '0;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    len_d       = '0;
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        in_ready_d = (state_d == S_FILL);
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FILL;
            len_q        <= '0;
            rd_q         <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= '0;
            in_ready_q   <= 1'b0;
            aec_ready_q  <= 1'b0;
            aec_ascii_q  <= 8'h00;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            line_drop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_q         <= rd_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            in_ready_q   <= in_ready_d;
            aec_ready_q  <= aec_ready_d;
            aec_ascii_q  <= aec_ascii_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            line_drop_q  <= line_drop_d;
        end
    end

    // line buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[len_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.aec_ready  = aec_ready_q;
    assign bus.aec_ascii  = aec_ascii_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
    assign bus.line_drop  = line_drop_q;
endmodule

// File: tb/tb_aec_line_feeder.sv
// Random and directed lines against a segment-level model of the feeder.
module tb_aec_line_feeder;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int TIMEOUT = 1024;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    aec_line_feeder_if ifc();

    aec_line_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: capture each AEC burst, count drop pulses and protocol slips
    bq_t cap;
    int  cap_done = 0, drop_cnt = 0, strobe_err = 0, stray = 0;
    int  t_first = 0, t_last = 0;
    bit  capturing = 0;

    always @(negedge clk) begin
        if (!rst) begin
            capturing = 0;
        end else begin
            if (ifc.line_drop) drop_cnt++;
            if (ifc.aec_ready) begin
                if (capturing) strobe_err++;
                capturing = 1;
                cap = {};
                cap.push_back(ifc.aec_ascii);
                t_first = cyc;
                t_last  = cyc;
            end else if (capturing) begin
                if (ifc.aec_ascii != 8'h00) begin
                    cap.push_back(ifc.aec_ascii);
                    t_last = cyc;
                end else begin
                    capturing = 0;
                    cap_done++;
                end
            end else if (ifc.aec_ascii != 8'h00) begin
                stray++;
            end
        end
    end

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // line model: whitespace vanishes, each '=' closes a segment; empty segments
    // are ignored, segments that cannot fit alongside '=' are dropped
    function automatic void model(input bq_t q, output int drops, output bq_t exp);
        bq_t seg;
        drops = 0;
        exp   = {};
        foreach (q[i]) begin
            if (q[i] == 8'h20 || q[i] == 8'h0D || q[i] == 8'h0A) continue;
            if (q[i] == 8'h3D) begin
                if (seg.size() == 0) continue;
                if (seg.size() > DEPTH - 1) drops++;
                else begin
                    exp = seg;
                    exp.push_back(8'h3D);
                end
                seg = {};
            end else begin
                seg.push_back(q[i]);
            end
        end
    endfunction

    function automatic bq_t rand_line();
        string cs = "0123456789+-*/()";
        string ws = " \r\n";
        bq_t   q;
        int    n;
        if ($urandom_range(3, 0) == 0) q.push_back(8'h3D);
        n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(34, 29)) : int'($urandom_range(8, 1));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(4, 0) == 0) q.push_back(ws[$urandom_range(2, 0)]);
            q.push_back(cs[$urandom_range(15, 0)]);
        end
        q.push_back(8'h3D);
        return q;
    endfunction

    // offer one byte once in_ready is seen; junk aec_valid while filling
    task automatic put_byte(input logic [7:0] b, output int t);
        int n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", integer'(n < 200), 1);
        ifc.in_valid   = 1'b1;
        ifc.in_data    = b;
        ifc.aec_valid  = ($urandom_range(2, 0) == 0);
        ifc.aec_result = 7'($urandom);
        t = cyc;
        @(posedge clk);
        #1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'($urandom);
        ifc.aec_valid = 1'b0;
    endtask

    // mode 0: AEC answers res; mode 1: AEC silent; mode 2: reset mid-SEND
    task automatic run_line(input bq_t q, input int mode, input int glo, input int ghi,
                            input int hold, input logic [6:0] res);
        int  drops, t, t_acc, d0, c0, n;
        bq_t exp;
        logic [6:0] r_exp;
        logic e_exp;
        model(q, drops, exp);
        d0 = drop_cnt;
        c0 = cap_done;
        t_acc = 0;
        foreach (q[i]) begin
            put_byte(q[i], t);
            t_acc = t;
            if (i != q.size() - 1) repeat ($urandom_range(ghi, glo)) @(posedge clk);
        end
        if (mode == 2) begin
            @(negedge clk);
            @(negedge clk);
            chk("rst_pre_strobe", integer'(ifc.aec_ready), 1);
            rst = 1'b0;
            @(negedge clk);
            #2;
            chk("rst_in_ready", integer'(ifc.in_ready), 0);
            chk("rst_aec_ready", integer'(ifc.aec_ready), 0);
            chk("rst_aec_ascii", integer'(ifc.aec_ascii), 0);
            chk("rst_out_valid", integer'(ifc.out_valid), 0);
            chk("rst_out_result", integer'(ifc.out_result), 0);
            chk("rst_out_err", integer'(ifc.out_err), 0);
            chk("rst_line_drop", integer'(ifc.line_drop), 0);
            rst = 1'b1;
            return;
        end
        if (exp.size() == 0) begin
            repeat (3) @(negedge clk);
            chk("drop_pulses", drop_cnt - d0, drops);
            chk("drop_no_send", cap_done - c0, 0);
            return;
        end
        n = 0;
        while (cap_done == c0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("burst_seen", cap_done - c0, 1);
        chk("drop_pulses", drop_cnt - d0, drops);
        chk("seq_len", cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++) chk("seq_char", integer'(cap[i]), integer'(exp[i]));
        chk("first_lat", t_first - t_acc, 2);
        chk("burst_span", t_last - t_first, exp.size() - 1);
        chk("wait_no_valid", integer'(ifc.out_valid), 0);
        if (mode == 1) begin
            n = 0;
            while (!ifc.out_valid && n < TIMEOUT + 100) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_valid", integer'(ifc.out_valid), 1);
            chk("tmo_lat", cyc - t_last, TIMEOUT);
            r_exp = 7'd0;
            e_exp = 1'b1;
        end else begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            ifc.aec_valid  = 1'b1;
            ifc.aec_result = res;
            @(negedge clk);
            ifc.aec_valid  = 1'b0;
            chk("res_valid", integer'(ifc.out_valid), 1);
            r_exp = res;
            e_exp = 1'b0;
        end
        chk("res_value", integer'(ifc.out_result), integer'(r_exp));
        chk("res_err", integer'(ifc.out_err), integer'(e_exp));
        for (int k = 0; k < hold; k++) begin
            ifc.aec_valid  = $urandom_range(1, 0);
            ifc.aec_result = 7'($urandom);
            @(negedge clk);
            chk("hold_valid", integer'(ifc.out_valid), 1);
            chk("hold_value", integer'(ifc.out_result), integer'(r_exp));
            chk("hold_err", integer'(ifc.out_err), integer'(e_exp));
            chk("hold_in_ready", integer'(ifc.in_ready), 0);
        end
        ifc.aec_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk("release_valid", integer'(ifc.out_valid), 0);
        chk("release_in_ready", integer'(ifc.in_ready), 1);
    endtask

    initial begin
        bq_t q;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = 8'h00;
        ifc.aec_valid  = 1'b0;
        ifc.aec_result = 7'd0;
        ifc.out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", integer'(ifc.in_ready), 0);
        chk("reset_aec_ready", integer'(ifc.aec_ready), 0);
        chk("reset_aec_ascii", integer'(ifc.aec_ascii), 0);
        chk("reset_out_valid", integer'(ifc.out_valid), 0);
        chk("reset_out_result", integer'(ifc.out_result), 0);
        chk("reset_out_err", integer'(ifc.out_err), 0);
        chk("reset_line_drop", integer'(ifc.line_drop), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", integer'(ifc.in_ready), 1);

        run_line(s2q("3+4="), 0, 0, 0, 0, 7'd7);
        run_line(s2q("(1+2)*3\r\n="), 0, 2, 2, 2, 7'd9);
        q = {};
        for (int i = 0; i < 40; i++) q.push_back(8'h30 + 8'(i % 10));
        q.push_back(8'h3D);
        run_line(q, 0, 0, 0, 0, 7'd0);
        run_line(s2q("2*3="), 0, 0, 0, 1, 7'd6);
        run_line(s2q("9-4="), 0, 0, 1, 20, 7'd5);
        run_line(s2q("8/2="), 1, 0, 0, 3, 7'd0);
        run_line(s2q("12+3="), 2, 0, 0, 0, 7'd0);
        run_line(s2q("1+1="), 0, 0, 0, 0, 7'd2);
        // boundary: 31 chars plus '=' fill the buffer exactly, 32 chars overflow
        q = {};
        for (int i = 0; i < DEPTH - 1; i++) q.push_back(8'h31);
        q.push_back(8'h3D);
        run_line(q, 0, 0, 0, 0, 7'd100);
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(8'h32);
        q.push_back(8'h3D);
        run_line(q, 0, 0, 0, 0, 7'd0);
        run_line(s2q("= 5="), 0, 0, 0, 0, 7'd5);

        for (int l = 0; l < 30; l++)
            run_line(rand_line(), 0, 0, int'($urandom_range(2, 0)), int'($urandom_range(5, 0)), 7'($urandom));

        chk("strobe_errors", strobe_err, 0);
        chk("stray_chars", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
